// File: rtl/uart_bus_slave_pkg.sv
// Shared register indices, FSM state encoding and divider helpers for the UART bus slave.
package uart_pkg;

    localparam logic [2:0] IDX_TX_DATA  = 3'd0;
    localparam logic [2:0] IDX_TX_CTRL  = 3'd1;
    localparam logic [2:0] IDX_TX_BUSY  = 3'd2;
    localparam logic [2:0] IDX_RX_DATA  = 3'd3;
    localparam logic [2:0] IDX_RX_VALID = 3'd4;
    localparam logic [2:0] IDX_BAUD_DIV = 3'd5;
    localparam logic [2:0] IDX_RX_ERR   = 3'd6;

    localparam int unsigned MIN_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] value, input logic [15:0] floor_val);
        return (value < floor_val) ? floor_val : value;
    endfunction

endpackage

// File: rtl/uart_bus_slave_if.sv
// Word-indexed register bus between the memory master and the UART slave.
interface uart_bus_slave_if #(parameter int LENGTH = 32);
    logic              sel;
    logic [LENGTH-1:0] HAddress;
    logic [LENGTH-1:0] HWData;
    logic              write_data_en;
    logic [LENGTH-1:0] HRData;

    modport master (output sel, HAddress, HWData, write_data_en, input HRData);
    modport slave  (input sel, HAddress, HWData, write_data_en, output HRData);
endinterface

// File: rtl/uart_bus_slave_rx_core.sv
// Receive side: 2-flop synchroniser, 8N1 deserialiser, byte strobe and framing-error strobe.
// IDLE: wait falling edge | START: confirm at half bit | DATA: 8 samples LSB first | STOP: check stop, hold until line high on error
module uart_rx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [15:0] baud_div,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        frame_err
);

    logic [1:0]  sync;
    logic        rx_s;
    logic        rx_prev;
    uart_state_t state;
    logic [15:0] cnt;
    logic [15:0] rx_div;
    logic [2:0]  bit_idx;
    logic        stop_wait;

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            rx_div    <= '0;
            bit_idx   <= '0;
            stop_wait <= 1'b0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], uart_rx};
            rx_prev   <= rx_s;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        rx_div <= baud_div;
                    end
                end
                START: begin
                    if (cnt == (rx_div >> 1) - 16'd1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == rx_div - 16'd1) begin
                        cnt     <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    // A bad stop bit parks here until the line recovers, so a low line is not taken as a new start.
                    if (stop_wait) begin
                        if (rx_s) begin
                            stop_wait <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (cnt == rx_div - 16'd1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_strobe <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            stop_wait <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_slave.sv
// UART bus responder: register file, TX serialiser and combinational read mux; RX lives in uart_rx_core.
// IDLE: line high, wait TX_CTRL | START: drive 0 | DATA: 8 bits LSB first | STOP: drive 1, then release BUSY
module uart_bus_slave
    import uart_pkg::*;
#(
    parameter int LENGTH       = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int MIN_DIV      = MIN_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    uart_bus_slave_if.slave   bus,
    output logic              uart_tx,
    input  logic              uart_rx
);

    logic [2:0]  idx;
    logic        wr;
    logic [7:0]  tx_data;
    logic [15:0] baud_div;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [1:0]  rx_err;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        frame_err;

    uart_state_t tx_state;
    logic        tx_busy;
    logic [15:0] tx_cnt;
    logic [15:0] tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_start;
    logic        unused_bits;
    logic [LENGTH-1:0] rdata;

    assign idx         = bus.HAddress[2:0];
    assign wr          = bus.sel && bus.write_data_en;
    assign tx_start    = wr && (idx == IDX_TX_CTRL) && bus.HWData[0] && (tx_state == IDLE);
    assign unused_bits = ^{bus.HAddress[LENGTH-1:3], bus.HWData[LENGTH-1:16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= '0;
            baud_div <= 16'(CLKS_PER_BIT);
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= '0;
        end else begin
            if (wr && idx == IDX_TX_DATA)
                tx_data <= bus.HWData[7:0];
            if (wr && idx == IDX_BAUD_DIV)
                baud_div <= clamp_div(bus.HWData[15:0], 16'(MIN_DIV));
            if (wr && idx == IDX_RX_VALID)
                rx_valid <= 1'b0;
            if (wr && idx == IDX_RX_ERR)
                rx_err <= '0;
            // Hardware sets are written last so they win over a bus clear on the same edge.
            if (rx_strobe) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
                if (rx_valid)
                    rx_err[1] <= 1'b1;
            end
            if (frame_err)
                rx_err[0] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_start) begin
                        tx_shift <= tx_data;
                        tx_div   <= baud_div;
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == tx_div - 16'd1) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt == tx_div - 16'd1) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            uart_tx  <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (tx_cnt == tx_div - 16'd1) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    uart_rx_core u_rx (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .baud_div  (baud_div),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err)
    );

    always_comb begin
        rdata = '0;
        case (idx)
            IDX_TX_DATA:  rdata[7:0]  = tx_data;
            IDX_TX_BUSY:  rdata[0]    = tx_busy;
            IDX_RX_DATA:  rdata[7:0]  = rx_data;
            IDX_RX_VALID: rdata[0]    = rx_valid;
            IDX_BAUD_DIV: rdata[15:0] = baud_div;
            IDX_RX_ERR:   rdata[1:0]  = rx_err;
            default:      rdata       = '0;
        endcase
    end

    assign bus.HRData = rdata;

endmodule

// File: tb/tb_uart_bus_slave.sv
// Scoreboard bench for uart_bus_slave: TX bit stream, RX capture, error flags, divider and reset behaviour.
module tb_uart_bus_slave;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic uart_rx;
    logic rx_drv = 1'b1;
    logic loopback = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] rd;
    logic        exp_q[$];
    logic [7:0]  rx_q[$];

    uart_bus_slave_if #(.LENGTH(32)) bus ();

    assign uart_rx = loopback ? uart_tx : rx_drv;

    uart_bus_slave #(.LENGTH(32), .CLKS_PER_BIT(16), .MIN_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] val);
        @(negedge clk);
        bus.sel = 1'b1; bus.write_data_en = 1'b1;
        bus.HAddress = 32'(idx); bus.HWData = val;
        @(negedge clk);
        bus.sel = 1'b0; bus.write_data_en = 1'b0; bus.HWData = '0;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] val);
        bus.HAddress = 32'(idx);
        #1 val = bus.HRData;
    endtask

    // Start a frame and follow it to the end: one expected line level per bit is queued and compared at mid-bit.
    task automatic tx_frame(input logic [7:0] b, input int div, input int wr_at,
                            input logic [2:0] wr_idx, input logic [31:0] wr_val);
        int ones = 0;
        bit done = 0;
        int rel;
        int exp_ones;
        logic e;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        exp_q.push_back(1'b1);
        bus_write(IDX_TX_DATA, 32'(b));
        bus_write(IDX_TX_CTRL, 32'd1);
        #1;
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL tx_start_low: uart_tx=%b expected 0", uart_tx); end
        for (int i = 0; i < 12 * div + 20 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (i == wr_at) begin
                bus.sel = 1'b1; bus.write_data_en = 1'b1; bus.HAddress = 32'(wr_idx); bus.HWData = wr_val;
            end else begin
                bus.sel = 1'b0; bus.write_data_en = 1'b0; bus.HAddress = 32'(IDX_TX_BUSY); bus.HWData = '0;
            end
            #1;
            if (i != wr_at) begin
                if (bus.HRData[0]) ones++; else done = 1;
            end
            rel = i - div / 2;
            if (rel >= 0 && rel % div == 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (uart_tx !== e) begin
                    failures++;
                    $display("FAIL tx_bit%0d byte=%02h: uart_tx=%b expected %b", rel / div, b, uart_tx, e);
                end
            end
        end
        exp_ones = 10 * div - ((wr_at >= 0 && wr_at < 10 * div) ? 1 : 0);
        checks++;
        if (!done) begin failures++; $display("FAIL tx_busy_timeout: busy never cleared"); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL tx_bits_left: %0d bits unsampled expected 0", exp_q.size()); end
        checks++;
        if (ones != exp_ones) begin failures++; $display("FAIL tx_busy_len: busy cycles=%0d expected %0d", ones, exp_ones); end
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL tx_idle_after: uart_tx=%b expected 1", uart_tx); end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int div);
        @(negedge clk); rx_drv = 1'b0;
        repeat (div) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (div) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (div) @(negedge clk);
        rx_drv = 1'b1;
        repeat (div) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sel = 1'b0; bus.write_data_en = 1'b0; bus.HAddress = '0; bus.HWData = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: uart_tx=%b expected 1", uart_tx); end
        bus_read(IDX_TX_BUSY, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_busy: got %0h expected 0", rd); end
        bus_read(IDX_RX_VALID, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_valid: got %0h expected 0", rd); end
        bus_read(IDX_RX_ERR, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_err: got %0h expected 0", rd); end
        bus_read(IDX_BAUD_DIV, rd);
        checks++; if (rd !== 32'd16) begin failures++; $display("FAIL reset_div: got %0d expected 16", rd); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_frame();
        tx_frame(8'hA5, 16, -1, IDX_TX_DATA, 32'd0);
        bus_read(IDX_TX_CTRL, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL tx_ctrl_read: got %0h expected 0", rd); end
        bus_read(IDX_TX_DATA, rd);
        checks++; if (rd !== 32'hA5) begin failures++; $display("FAIL tx_data_read: got %0h expected a5", rd); end
    endtask

    task automatic test_rx_loop();
        bit got = 0;
        loopback = 1'b1;
        rx_q.push_back(8'h3C);
        tx_frame(8'h3C, 16, -1, IDX_TX_DATA, 32'd0);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            bus_read(IDX_RX_VALID, rd);
            if (rd[0]) got = 1;
        end
        loopback = 1'b0;
        checks++;
        if (!got) begin failures++; $display("FAIL rx_loop_valid: RX_VALID never set"); end
        bus_read(IDX_RX_DATA, rd);
        checks++;
        if (rd !== 32'(rx_q[0])) begin failures++; $display("FAIL rx_loop_data: got %0h expected %0h", rd, rx_q[0]); end
        rx_q.delete();
        bus_write(IDX_RX_VALID, 32'd0);
        bus_read(IDX_RX_VALID, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rx_valid_clear: got %0h expected 0", rd); end
    endtask

    task automatic test_rx_overrun();
        bus_write(IDX_RX_ERR, 32'd0);
        rx_q.push_back(8'h11);
        rx_send(8'h11, 1'b1, 16);
        rx_q.push_back(8'h22);
        rx_send(8'h22, 1'b1, 16);
        bus_read(IDX_RX_DATA, rd);
        checks++;
        if (rd !== 32'(rx_q[$])) begin failures++; $display("FAIL rx_second_data: got %0h expected %0h", rd, rx_q[$]); end
        rx_q.delete();
        bus_read(IDX_RX_ERR, rd);
        checks++; if (rd !== 32'd2) begin failures++; $display("FAIL rx_overrun: got %0h expected 2", rd); end
        bus_read(IDX_RX_VALID, rd);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL rx_valid_set: got %0h expected 1", rd); end
    endtask

    task automatic test_framing();
        bus_write(IDX_RX_ERR, 32'd0);
        bus_write(IDX_RX_VALID, 32'd0);
        bus_read(IDX_RX_ERR, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL err_clear: got %0h expected 0", rd); end
        rx_send(8'h55, 1'b0, 16);
        bus_read(IDX_RX_ERR, rd);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL rx_framing: got %0h expected 1", rd); end
        bus_read(IDX_RX_DATA, rd);
        checks++; if (rd !== 32'h22) begin failures++; $display("FAIL rx_data_kept: got %0h expected 22", rd); end
        bus_read(IDX_RX_VALID, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rx_valid_no_set: got %0h expected 0", rd); end
        // A clean frame afterwards proves the receiver left its error wait state.
        rx_send(8'h81, 1'b1, 16);
        bus_read(IDX_RX_DATA, rd);
        checks++; if (rd !== 32'h81) begin failures++; $display("FAIL rx_after_framing: got %0h expected 81", rd); end
    endtask

    task automatic test_baud_clamp();
        logic [31:0] wv [4] = '{32'd2, 32'd0, 32'd5, 32'd16};
        logic [31:0] ev [4] = '{32'd4, 32'd4, 32'd5, 32'd16};
        for (int i = 0; i < 4; i++) begin
            bus_write(IDX_BAUD_DIV, wv[i]);
            bus_read(IDX_BAUD_DIV, rd);
            checks++;
            if (rd !== ev[i]) begin failures++; $display("FAIL baud_clamp wr=%0d: got %0d expected %0d", wv[i], rd, ev[i]); end
        end
    endtask

    task automatic test_baud_midframe();
        tx_frame(8'h96, 16, 40, IDX_BAUD_DIV, 32'd8);
        bus_read(IDX_BAUD_DIV, rd);
        checks++; if (rd !== 32'd8) begin failures++; $display("FAIL baud_mid_read: got %0d expected 8", rd); end
        tx_frame(8'h5A, 8, -1, IDX_TX_DATA, 32'd0);
        bus_write(IDX_BAUD_DIV, 32'd16);
    endtask

    task automatic test_busy_ignore();
        bit quiet = 1;
        tx_frame(8'hC3, 16, 50, IDX_TX_CTRL, 32'd1);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            bus_read(IDX_TX_BUSY, rd);
            if (rd[0] !== 1'b0 || uart_tx !== 1'b1) quiet = 0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL busy_ignore: second frame started, expected line idle"); end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1;
        bus_write(IDX_TX_DATA, 32'h00);
        bus_write(IDX_TX_CTRL, 32'd1);
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL reset_mid_pre: uart_tx=%b expected 0", uart_tx); end
        rst = 1'b1;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_mid_tx: uart_tx=%b expected 1", uart_tx); end
        bus_read(IDX_TX_BUSY, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_mid_busy: got %0h expected 0", rd); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (uart_tx !== 1'b1) quiet = 0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL reset_mid_idle: frame resumed after reset"); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_rx_loop();
        test_rx_overrun();
        test_framing();
        test_baud_clamp();
        test_baud_midframe();
        test_busy_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
